dct_quant_zigzag: RTL
=====================

// Module: dct_quant_zigzag
// PURPOSE
//  Downstream consumer of dct_v2. Captures the 64 signed DCT coefficients of one
//  8x8 block (raster order, one per exportProduct pulse), quantizes each by a
//  position-dependent rounding right-shift with 16-bit saturation, and streams
//  them out in JPEG zigzag order over a valid/ready interface. A ping-pong
//  buffer (2 x 64 x 16 bit) lets block N+1 load while block N drains.
// PARAMETERS
//  QSHIFT    3   base right-shift applied to every coefficient (0..15)
//  OUT_W     16  quantized output width; saturation bound is +/-(2^(OUT_W-1)-1)
// PORTS
//  clk          in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-low reset
//  coef_valid   in   1      coefficient strobe; tie to dct_v2 exportProduct
//  coef_in      in   32     signed coefficient; tie to dct_v2 data_out
//  out_ready    in   1      sink accepts out_data this cycle
//  out_valid    out  1      out_data/out_index/out_last are valid
//  out_data     out  OUT_W  signed quantized coefficient
//  out_index    out  6      raster index (row*8+col) of the current output
//  out_last     out  1      high with the 64th output of a block (index 63)
//  in_stall     out  1      both banks hold undrained blocks; coef_valid is dropped
//  overflow_err out  1      sticky: a coefficient was dropped while in_stall
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0, both banks empty, write bank=0,
//   read bank=0, write and read counters 0. Reset mid-block discards all data.
//  Quantization (input stage, 1 register): pos p=raster count; r=p[5:3], c=p[2:0];
//   s = QSHIFT + ((r+c)>>2). m=|coef_in|; q = (m + (s?2^(s-1):0)) >> s;
//   sign restored (round half away from zero); q clipped to 2^(OUT_W-1)-1
//   before sign restore, so result range is symmetric. Use 33-bit magnitude.
//  Write side: each accepted coef_valid increments wr_cnt (0..63, raster order);
//   the quantized value is written to the write bank at address wr_cnt one cycle
//   later. On the write of address 63 the bank's full flag sets, wr_cnt wraps
//   to 0 and the write bank toggles.
//  in_stall = full[write bank] (registered). coef_valid while in_stall: sample
//   dropped, wr_cnt unchanged, overflow_err sets and stays set until reset.
//   A bank freed in the same cycle as a dropped sample does not rescue it.
//  Read FSM: IDLE -> FETCH -> STREAM -> (FETCH | IDLE).
//   IDLE: wait full[read bank]. FETCH: issue synchronous RAM read of
//   zigzag(rd_cnt); 1 cycle. STREAM: out_valid=1; hold out_data/out_index/
//   out_last stable while out_ready=0. On out_valid&&out_ready: if rd_cnt<63
//   increment and prefetch next so the next word is valid the following cycle
//   (full throughput, 1 word/cycle with out_ready held high); if rd_cnt=63,
//   clear full[read bank], toggle read bank, rd_cnt=0, go FETCH if other bank
//   full else IDLE (out_valid low that cycle).
//  Zigzag sequence starts 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5 ... ends
//   61,54,47,55,62,63 (fixed 64-entry ROM).
//  Latency: 64th coef_valid at edge T -> RAM write T+1 -> FETCH T+2 ->
//   out_valid high after edge T+3.
//  Simultaneous: write of one bank and drain of the other in the same cycle is
//   legal; a block becomes readable no earlier than the cycle after its full
//   flag sets.
// TESTING
//  1 QSHIFT=3; block with raster0=1000, raster63=6400, rest 0 -> first output
//    index0 data 125; last output index63 data 100, out_last=1; 62 zeros between.
//  2 raster0=-1000, raster1=-4 -> outputs -125 at index0, -1 at index1
//    (-0.5 rounds away from zero); raster0=+3 -> 0 (0.375 rounds to 0).
//  3 raster0=2^30, raster9=-(2^30) -> 32767 and -32767; overflow_err stays 0.
//  4 Three back-to-back blocks, out_ready=0 throughout -> in_stall after block 2,
//    block-3 samples dropped, overflow_err=1; then out_ready=1 -> blocks 1,2
//    emerge complete and in order, 128 outputs, out_last twice.
//  5 out_ready toggled pseudo-randomly -> zigzag index order exact, out_data
//    stable while stalled, no loss or duplication over 4 blocks.
//  6 reset=0 at output word 20 of a block -> all outputs 0 async; next full block
//    after release emits from index 0 with correct data.

Source files
------------

// File: rtl/dct_quant_zigzag_if.sv
// Coefficient input and zigzag output stream between dct_v2, the quantizer and its sink.
interface dct_quant_zigzag_if #(
  parameter int unsigned OUT_W = 16
);
  logic                    coef_valid;
  logic signed [31:0]      coef_in;
  logic                    out_ready;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_data;
  logic [5:0]              out_index;
  logic                    out_last;
  logic                    in_stall;
  logic                    overflow_err;

  modport master (
    output coef_valid, coef_in, out_ready,
    input  out_valid, out_data, out_index, out_last, in_stall, overflow_err
  );

  modport slave (
    input  coef_valid, coef_in, out_ready,
    output out_valid, out_data, out_index, out_last, in_stall, overflow_err
  );
endinterface

// File: rtl/dct_quant_zigzag.sv
// Quantizes one 8x8 block of raster-order DCT coefficients into a ping-pong buffer
// and streams each completed block out in JPEG zigzag order.
module dct_quant_zigzag #(
  parameter int unsigned QSHIFT = 3,
  parameter int unsigned OUT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  dct_quant_zigzag_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

  localparam logic [5:0] ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
  localparam logic [32:0] QMAX = (33'd1 << (OUT_W - 1)) - 33'd1;

  logic [OUT_W-1:0] mem [128];

  logic [5:0]       wr_cnt, st_addr;
  logic             st_valid;
  logic [OUT_W-1:0] st_data;
  logic             wr_bank, wr_bank_n, rd_bank;
  logic [1:0]       full, full_n;
  logic             in_stall, overflow_err;
  logic             hazard, accept;

  state_t           state, state_n;
  logic [5:0]       rd_cnt, ld_cnt, ld_idx;
  logic             load, finish, out_valid;
  logic [OUT_W-1:0] out_data;
  logic [5:0]       out_index;
  logic             out_last;

  logic             neg;
  logic [3:0]       rc;
  logic [4:0]       s;
  logic [32:0]      ext, mag, rnd, q_mag;
  logic [OUT_W-1:0] q_sat, q_val;

  always_comb begin
    neg   = bus.coef_in[31];
    ext   = {bus.coef_in[31], bus.coef_in};
    mag   = neg ? -ext : ext;
    rc    = {1'b0, wr_cnt[5:3]} + {1'b0, wr_cnt[2:0]};
    s     = 5'(QSHIFT) + 5'(rc >> 2);
    rnd   = (s == 5'd0) ? '0 : (33'd1 << (s - 5'd1));
    q_mag = (mag + rnd) >> s;
    q_sat = (q_mag > QMAX) ? QMAX[OUT_W-1:0] : q_mag[OUT_W-1:0];
    q_val = neg ? -q_sat : q_sat;
  end

  // The sample landing on the same edge as a block's final write would go to the
  // bank that is about to become current; drop it if that bank is still undrained.
  assign hazard = st_valid && (st_addr == 6'd63) && full[~wr_bank];
  assign accept = bus.coef_valid && !in_stall && !hazard;

  always_comb begin
    state_n   = state;
    load      = 1'b0;
    finish    = 1'b0;
    out_valid = 1'b0;
    ld_cnt    = rd_cnt;
    case (state)
      IDLE:   if (full[rd_bank]) state_n = FETCH;
      FETCH: begin
        load    = 1'b1;
        state_n = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          if (rd_cnt != 6'd63) begin
            load   = 1'b1;
            ld_cnt = rd_cnt + 6'd1;
          end else begin
            finish  = 1'b1;
            state_n = full[~rd_bank] ? FETCH : IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    ld_idx = ZZ[ld_cnt];
  end

  always_comb begin
    full_n    = full;
    wr_bank_n = wr_bank;
    if (finish) full_n[rd_bank] = 1'b0;
    if (st_valid && st_addr == 6'd63) begin
      full_n[wr_bank] = 1'b1;
      wr_bank_n       = ~wr_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (st_valid) mem[{wr_bank, st_addr}] <= st_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt       <= '0;
      st_addr      <= '0;
      st_valid     <= 1'b0;
      st_data      <= '0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      full         <= '0;
      in_stall     <= 1'b0;
      overflow_err <= 1'b0;
      state        <= IDLE;
      rd_cnt       <= '0;
      out_data     <= '0;
      out_index    <= '0;
      out_last     <= 1'b0;
    end else begin
      st_valid <= accept;
      if (accept) begin
        st_addr <= wr_cnt;
        st_data <= q_val;
        wr_cnt  <= wr_cnt + 6'd1;
      end
      if (bus.coef_valid && !accept) overflow_err <= 1'b1;
      full     <= full_n;
      wr_bank  <= wr_bank_n;
      in_stall <= full_n[wr_bank_n];
      state    <= state_n;
      if (load) begin
        rd_cnt    <= ld_cnt;
        out_data  <= mem[{rd_bank, ld_idx}];
        out_index <= ld_idx;
        out_last  <= (ld_cnt == 6'd63);
      end
      if (finish) begin
        rd_cnt   <= '0;
        rd_bank  <= ~rd_bank;
        out_last <= 1'b0;
      end
    end
  end

  assign bus.out_valid    = out_valid;
  assign bus.out_data     = out_data;
  assign bus.out_index    = out_index;
  assign bus.out_last     = out_last;
  assign bus.in_stall     = in_stall;
  assign bus.overflow_err = overflow_err;
endmodule
